dino_sprite_fetch: RTL and testbench

Read-side engine for the two-frame 64×32 RGB565 sprite sheet ROM (cactus/dino animation). It sits between the VGA pixel counters and the synchronous sprite ROM. It turns the current pixel coordinate into a ROM address, absorbs the ROM's one-cycle read latency, and toggles between the two 32×32 animation frames. It emits a pipelined, transparency-keyed pixel with a hit flag for the compositor.

---
 rtl/dino_sprite_fetch.sv | 124 ++++++++++++
 tb/tb_dino_sprite_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_sprite_fetch.sv
// rtl/dino_sprite_fetch.sv - sprite sheet read engine: pixel to ROM address, latency alignment, animation frame toggle
module dino_sprite_fetch #(
    parameter int          FRAME_W     = 32,
    parameter int          FRAME_H     = 32,
    parameter int          SHEET_W     = 64,
    parameter int          ANIM_PERIOD = 8,
    parameter logic [15:0] KEY_COLOR   = 16'hFFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [9:0]  i_pixel_x,
    input  logic [9:0]  i_pixel_y,
    input  logic        i_pixel_valid,
    input  logic        i_frame_tick,
    input  logic [9:0]  i_sprite_x,
    input  logic [9:0]  i_sprite_y,
    input  logic        i_anim_en,
    output logic [11:0] o_rom_addr,
    input  logic [15:0] i_rom_data,
    output logic [15:0] o_pix_rgb,
    output logic        o_pix_hit,
    output logic        o_frame_sel
);

    localparam int CNT_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam int FXW   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int FYW   = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_PERIOD - 1);

    logic [9:0]       r_pos_x;
    logic [9:0]       r_pos_y;
    logic [CNT_W-1:0] r_tick_cnt;
    logic             r_frame_sel;
    logic [11:0]      r_rom_addr;
    logic             r_v1;
    logic             r_v2;
    logic             r_pix_hit;
    logic [15:0]      r_pix_rgb;

    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic        w_dx_ok;
    logic        w_dy_ok;
    logic        w_in_box;
    logic [11:0] w_addr;
    logic        w_opaque;

    // Stage 0: offsets from the latched sprite origin; a negative offset
    // sets bit 10, which the range test rejects, so off-screen parts clip.
    assign w_dx     = {1'b0, i_pixel_x} - {1'b0, r_pos_x};
    assign w_dy     = {1'b0, i_pixel_y} - {1'b0, r_pos_y};
    assign w_dx_ok  = ~w_dx[10] && (w_dx < 11'(FRAME_W));
    assign w_dy_ok  = ~w_dy[10] && (w_dy < 11'(FRAME_H));
    assign w_in_box = i_pixel_valid && w_dx_ok && w_dy_ok;
    assign w_addr   = 12'(w_dy[FYW-1:0]) * 12'(SHEET_W)
                    + (r_frame_sel ? 12'(FRAME_W) : 12'd0)
                    + 12'(w_dx[FXW-1:0]);
    assign w_opaque = (i_rom_data != KEY_COLOR);

    // Sprite position is only sampled at the frame boundary to avoid tearing
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pos_x <= 10'd0;
            r_pos_y <= 10'd0;
        end else if (i_frame_tick) begin
            r_pos_x <= i_sprite_x;
            r_pos_y <= i_sprite_y;
        end
    end

    // Animation divider: frame half flips when the tick counter wraps
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tick_cnt  <= '0;
            r_frame_sel <= 1'b0;
        end else if (i_frame_tick && i_anim_en) begin
            if (r_tick_cnt == CNT_LAST) begin
                r_tick_cnt  <= '0;
                r_frame_sel <= ~r_frame_sel;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // Stage 1: issue ROM address for in-box pixels; address holds otherwise
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rom_addr <= 12'd0;
            r_v1       <= 1'b0;
        end else begin
            r_v1 <= w_in_box;
            if (w_in_box) begin
                r_rom_addr <= w_addr;
            end
        end
    end

    // Stage 2: track validity alongside the ROM's internal data register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
        end
    end

    // Stage 3: key out transparent texels and blank the colour on a miss
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pix_hit <= 1'b0;
            r_pix_rgb <= 16'h0000;
        end else begin
            r_pix_hit <= r_v2 && w_opaque;
            r_pix_rgb <= (r_v2 && w_opaque) ? i_rom_data : 16'h0000;
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_pix_hit   = r_pix_hit;
    assign o_pix_rgb   = r_pix_rgb;
    assign o_frame_sel = r_frame_sel;

endmodule

// File: tb/tb_dino_sprite_fetch.sv
// tb/tb_dino_sprite_fetch.sv - self-checking bench for dino_sprite_fetch
module tb_dino_sprite_fetch;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [9:0]  i_pixel_x;
    logic [9:0]  i_pixel_y;
    logic        i_pixel_valid;
    logic        i_frame_tick;
    logic [9:0]  i_sprite_x;
    logic [9:0]  i_sprite_y;
    logic        i_anim_en;
    logic [11:0] o_rom_addr;
    logic [15:0] rom_data;
    logic [15:0] o_pix_rgb;
    logic        o_pix_hit;
    logic        o_frame_sel;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [0:4095];

    typedef struct packed {
        logic        hit;
        logic [15:0] rgb;
    } pix_t;

    pix_t   q[$];
    pix_t   m_pix;
    int     m_addr;
    logic   m_fs;
    int     m_ticks;
    int     m_pos_x;
    int     m_pos_y;
    logic   check_en = 1'b0;

    dino_sprite_fetch dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_pixel_x    (i_pixel_x),
        .i_pixel_y    (i_pixel_y),
        .i_pixel_valid(i_pixel_valid),
        .i_frame_tick (i_frame_tick),
        .i_sprite_x   (i_sprite_x),
        .i_sprite_y   (i_sprite_y),
        .i_anim_en    (i_anim_en),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (rom_data),
        .o_pix_rgb    (o_pix_rgb),
        .o_pix_hit    (o_pix_hit),
        .o_frame_sel  (o_frame_sel)
    );

    always #5 clk = ~clk;

    // synchronous sprite ROM
    always @(posedge clk) rom_data <= mem[o_rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: what the screen pixel must be, three cycles on
    always @(posedge clk) begin
        pix_t e;
        int   dx, dy, a;
        logic [15:0] d;
        e.hit = 1'b0;
        e.rgb = 16'h0000;
        if (i_reset) begin
            q.delete();
            m_addr = 0; m_fs = 1'b0; m_ticks = 0; m_pos_x = 0; m_pos_y = 0;
            q.push_back(e);
            check_en = 1'b1;
        end else begin
            dx = int'(i_pixel_x) - m_pos_x;
            dy = int'(i_pixel_y) - m_pos_y;
            if (i_pixel_valid && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
                a = dy * 64 + (m_fs ? 32 : 0) + dx;
                m_addr = a;
                d = mem[a];
                e.hit = (d != 16'hFFFF);
                e.rgb = e.hit ? d : 16'h0000;
            end
            q.push_back(e);
            if (q.size() > 3) void'(q.pop_front());
            if (i_frame_tick) begin
                m_pos_x = int'(i_sprite_x);
                m_pos_y = int'(i_sprite_y);
                if (i_anim_en) begin
                    m_ticks++;
                    if (m_ticks == 8) begin
                        m_ticks = 0;
                        m_fs = ~m_fs;
                    end
                end
            end
        end
        if (q.size() == 3) m_pix = q[0];
        else begin
            m_pix.hit = 1'b0;
            m_pix.rgb = 16'h0000;
        end
    end

    // continuous comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_rom_addr", 32'(o_rom_addr), 32'(m_addr));
            chk("model_pix_hit", 32'(o_pix_hit), 32'(m_pix.hit));
            chk("model_pix_rgb", 32'(o_pix_rgb), 32'(m_pix.rgb));
            chk("model_frame_sel", 32'(o_frame_sel), 32'(m_fs));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input int x, input int y);
        i_pixel_x = 10'(x);
        i_pixel_y = 10'(y);
        i_pixel_valid = 1'b1;
        step();
        i_pixel_valid = 1'b0;
    endtask

    task automatic tick_pulse();
        i_frame_tick = 1'b1;
        step();
        i_frame_tick = 1'b0;
        step();
    endtask

    task automatic pix_result(input int x, input int y, input logic eh, input logic [15:0] er, input string nm);
        send_pix(x, y);
        step();
        step();
        chk({nm, "_hit"}, 32'(o_pix_hit), 32'(eh));
        chk({nm, "_rgb"}, 32'(o_pix_rgb), 32'(er));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 7 + 3);
        mem[0] = 16'h07E0;
        mem[1] = 16'hFFFF;
        mem[2] = 16'hFFFE;

        i_reset = 1'b1; i_pixel_x = '0; i_pixel_y = '0; i_pixel_valid = 1'b0;
        i_frame_tick = 1'b0; i_sprite_x = '0; i_sprite_y = '0; i_anim_en = 1'b0;
        step();
        step();
        chk("reset_rom_addr", 32'(o_rom_addr), 32'd0);
        chk("reset_pix_hit", 32'(o_pix_hit), 32'd0);
        chk("reset_pix_rgb", 32'(o_pix_rgb), 32'd0);
        chk("reset_frame_sel", 32'(o_frame_sel), 32'd0);
        i_reset = 1'b0;

        // static frame
        i_sprite_x = 10'd100; i_sprite_y = 10'd50;
        tick_pulse();
        send_pix(100, 50);
        chk("static_addr", 32'(o_rom_addr), 32'd0);
        step();
        chk("static_not_early", 32'(o_pix_hit), 32'd0);
        step();
        chk("static_hit", 32'(o_pix_hit), 32'd1);
        chk("static_rgb", 32'(o_pix_rgb), 32'h07E0);

        // transparency
        pix_result(101, 50, 1'b0, 16'h0000, "key");
        pix_result(102, 50, 1'b1, 16'hFFFE, "near_key");

        // addressing corner, frame 0
        send_pix(131, 81);
        chk("corner_addr_f0", 32'(o_rom_addr), 32'd2015);
        step(); step();
        pix_result(132, 81, 1'b0, 16'h0000, "right_edge");
        pix_result(131, 82, 1'b0, 16'h0000, "bottom_edge");

        // animation
        i_anim_en = 1'b1;
        repeat (7) tick_pulse();
        chk("anim_7", 32'(o_frame_sel), 32'd0);
        tick_pulse();
        chk("anim_8", 32'(o_frame_sel), 32'd1);
        send_pix(131, 81);
        chk("corner_addr_f1", 32'(o_rom_addr), 32'd2047);
        step(); step();
        repeat (7) tick_pulse();
        chk("anim_15", 32'(o_frame_sel), 32'd1);
        tick_pulse();
        chk("anim_16", 32'(o_frame_sel), 32'd0);
        repeat (3) tick_pulse();
        i_anim_en = 1'b0;
        repeat (20) tick_pulse();
        chk("anim_hold", 32'(o_frame_sel), 32'd0);
        i_anim_en = 1'b1;
        repeat (4) tick_pulse();
        chk("anim_resume_7", 32'(o_frame_sel), 32'd0);
        tick_pulse();
        chk("anim_resume_8", 32'(o_frame_sel), 32'd1);
        i_anim_en = 1'b0;

        // clipping and latching (frame_sel = 1)
        i_sprite_x = 10'd620; i_sprite_y = 10'd50;
        tick_pulse();
        pix_result(639, 50, 1'b1, 16'h0168, "clip_639");
        pix_result(0, 50, 1'b0, 16'h0000, "clip_nowrap");
        pix_result(619, 50, 1'b0, 16'h0000, "clip_left");
        i_sprite_x = 10'd0;
        pix_result(0, 50, 1'b0, 16'h0000, "latch_col0");
        pix_result(620, 50, 1'b1, 16'h00E3, "latch_620");

        // reset during a continuous in-box stream
        i_sprite_x = 10'd0; i_sprite_y = 10'd0;
        tick_pulse();
        for (int i = 0; i < 40; i++) begin
            i_pixel_x = 10'(i % 32);
            i_pixel_y = 10'd5;
            i_pixel_valid = 1'b1;
            i_reset = (i == 10);
            step();
            if (i == 10) begin
                chk("mid_reset_addr", 32'(o_rom_addr), 32'd0);
                chk("mid_reset_fs", 32'(o_frame_sel), 32'd0);
            end
            if (i >= 10 && i <= 12) chk("mid_reset_hit_low", 32'(o_pix_hit), 32'd0);
            if (i == 13) begin
                chk("mid_reset_first_hit", 32'(o_pix_hit), 32'd1);
                chk("mid_reset_first_rgb", 32'(o_pix_rgb), 32'h0910);
            end
        end
        i_reset = 1'b0;
        i_pixel_valid = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
